// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: buffered UART transmitter (FIFO + start/data/parity/stop serialiser).
// Ports: clk, resetn (async low), uart_tx_en/uart_tx_data write side,
//        uart_txd serial out, uart_tx_full, uart_tx_busy, uart_tx_dropped status.
`timescale 1ns/1ps
module uart_tx_fifo #(
    parameter int CLK_HZ       = 12000000,
    parameter int BIT_RATE     = 9600,
    parameter int PAYLOAD_BITS = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    uart_tx_en,
    input  logic [PAYLOAD_BITS-1:0] uart_tx_data,
    output logic                    uart_txd,
    output logic                    uart_tx_full,
    output logic                    uart_tx_busy,
    output logic                    uart_tx_dropped
);

    localparam int CYCLES_PER_BIT = CLK_HZ / BIT_RATE;
    localparam int CNT_W  = (CYCLES_PER_BIT > 1) ? $clog2(CYCLES_PER_BIT) : 1;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_FW = PTR_W + 1;

    localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(CYCLES_PER_BIT - 1);
    localparam logic [3:0]        DATA_LAST = 4'(PAYLOAD_BITS - 1);
    localparam logic [3:0]        STOP_LAST = 4'(STOP_BITS - 1);
    localparam logic [CNT_FW-1:0] DEPTH     = CNT_FW'(FIFO_DEPTH);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    logic [PAYLOAD_BITS-1:0] mem_q [FIFO_DEPTH];

    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CNT_FW-1:0]       count_q, count_d;
    logic [2:0]              state_q, state_d;
    logic [CNT_W-1:0]        bit_cnt_q, bit_cnt_d;
    logic [3:0]              idx_q, idx_d;
    logic [PAYLOAD_BITS-1:0] shift_q, shift_d;
    logic                    par_q, par_d;
    logic                    txd_q, txd_d;
    logic                    dropped_q, dropped_d;

    logic full;
    logic push;
    logic pop;
    logic bit_end;

    assign full    = (count_q == DEPTH);
    assign push    = uart_tx_en && !full;
    assign bit_end = (bit_cnt_q == BIT_LAST);

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_end ? '0 : bit_cnt_q + CNT_W'(1);
        idx_d     = idx_q;
        shift_d   = shift_q;
        par_d     = par_q;
        txd_d     = 1'b1;
        pop       = 1'b0;

        // txd_d follows the current state, so the line lags the FSM by one cycle
        unique case (state_q)
            S_IDLE: begin
                bit_cnt_d = '0;
                if (count_q != '0) begin
                    pop     = 1'b1;
                    state_d = S_START;
                end
            end
            S_START: begin
                txd_d = 1'b0;
                if (bit_end) begin
                    state_d = S_DATA;
                    idx_d   = '0;
                end
            end
            S_DATA: begin
                txd_d = shift_q[0];
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (idx_q == DATA_LAST) begin
                        idx_d   = '0;
                        state_d = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            S_PARITY: begin
                txd_d = par_q;
                if (bit_end) begin
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                txd_d = 1'b1;
                if (bit_end) begin
                    if (idx_q == STOP_LAST) begin
                        idx_d = '0;
                        // chain straight into the next start bit when data waits
                        if (count_q != '0) begin
                            pop     = 1'b1;
                            state_d = S_START;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // parity taken from the whole popped word, before any shifting
        if (pop) begin
            shift_d   = mem_q[rd_ptr_q];
            par_d     = (PARITY == 1) ? ~^mem_q[rd_ptr_q] : ^mem_q[rd_ptr_q];
            bit_cnt_d = '0;
        end
    end

    always_comb begin
        wr_ptr_d  = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d  = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d   = count_q;
        if (push && !pop) begin
            count_d = count_q + CNT_FW'(1);
        end else if (!push && pop) begin
            count_d = count_q - CNT_FW'(1);
        end
        // a write while full is lost even if a pop frees a slot this cycle
        dropped_d = uart_tx_en && full;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= uart_tx_data;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            state_q   <= S_IDLE;
            bit_cnt_q <= '0;
            idx_q     <= '0;
            shift_q   <= '0;
            par_q     <= 1'b0;
            txd_q     <= 1'b1;
            dropped_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            idx_q     <= idx_d;
            shift_q   <= shift_d;
            par_q     <= par_d;
            txd_q     <= txd_d;
            dropped_q <= dropped_d;
        end
    end

    assign uart_txd        = txd_q;
    assign uart_tx_full    = full;
    assign uart_tx_busy    = (state_q != S_IDLE) || (count_q != '0);
    assign uart_tx_dropped = dropped_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: scoreboard bench for uart_tx_fifo.
// Four instances: default rate, fast (16 cyc/bit), even parity + 2 stop, odd parity.
`timescale 1ns/1ps
module tb_uart_tx_fifo;

    logic       clk;
    logic       resetn;
    logic [3:0] en;
    logic [7:0] din;
    logic [3:0] txd_w;
    logic [3:0] full_w;
    logic [3:0] busy_w;
    logic [3:0] drop_w;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int first_start;
    logic first_par;
    logic [7:0] sb_q [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx_fifo u_def (
        .clk(clk), .resetn(resetn),
        .uart_tx_en(en[0]), .uart_tx_data(din),
        .uart_txd(txd_w[0]), .uart_tx_full(full_w[0]),
        .uart_tx_busy(busy_w[0]), .uart_tx_dropped(drop_w[0])
    );

    uart_tx_fifo #(.CLK_HZ(160), .BIT_RATE(10)) u_fast (
        .clk(clk), .resetn(resetn),
        .uart_tx_en(en[1]), .uart_tx_data(din),
        .uart_txd(txd_w[1]), .uart_tx_full(full_w[1]),
        .uart_tx_busy(busy_w[1]), .uart_tx_dropped(drop_w[1])
    );

    uart_tx_fifo #(.CLK_HZ(160), .BIT_RATE(10), .PARITY(2), .STOP_BITS(2)) u_even (
        .clk(clk), .resetn(resetn),
        .uart_tx_en(en[2]), .uart_tx_data(din),
        .uart_txd(txd_w[2]), .uart_tx_full(full_w[2]),
        .uart_tx_busy(busy_w[2]), .uart_tx_dropped(drop_w[2])
    );

    uart_tx_fifo #(.CLK_HZ(160), .BIT_RATE(10), .PARITY(1)) u_odd (
        .clk(clk), .resetn(resetn),
        .uart_tx_en(en[3]), .uart_tx_data(din),
        .uart_txd(txd_w[3]), .uart_tx_full(full_w[3]),
        .uart_tx_busy(busy_w[3]), .uart_tx_dropped(drop_w[3])
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wr(input int ch, input logic [7:0] v, input bit keep);
        en      = '0;
        en[ch]  = 1'b1;
        din     = v;
        if (keep) sb_q.push_back(v);
        @(negedge clk);
        en = '0;
    endtask

    task automatic rx_frames(input int ch, input int n, input int cpb,
                             input int par, input int nstop);
        int nb;
        int w;
        int t0;
        int tprev;
        logic [15:0] bits;
        logic v0;
        logic v1;
        logic shape;
        logic stop_ok;
        logic [7:0] d;
        logic [7:0] e;
        nb    = 9 + ((par != 0) ? 1 : 0) + nstop;
        tprev = 0;
        for (int f = 0; f < n; f++) begin
            w = 0;
            while (txd_w[ch] !== 1'b0 && w < 40000) begin
                @(negedge clk);
                w++;
            end
            check("rx_start", {31'd0, txd_w[ch]}, 32'd0);
            if (txd_w[ch] !== 1'b0) return;
            t0 = cyc;
            if (f == 0) first_start = t0;
            else check("b2b_gap", t0 - tprev, nb * cpb);
            tprev = t0;
            shape = 1'b1;
            bits  = '0;
            for (int b = 0; b < nb; b++) begin
                v0 = txd_w[ch];
                repeat (cpb - 1) @(negedge clk);
                v1 = txd_w[ch];
                if (v0 !== v1) shape = 1'b0;
                bits[b] = v0;
                @(negedge clk);
            end
            check("bit_len", {31'd0, shape}, 32'd1);
            stop_ok = 1'b1;
            for (int s = 0; s < nstop; s++) begin
                if (bits[nb-1-s] !== 1'b1) stop_ok = 1'b0;
            end
            check("stop", {31'd0, stop_ok}, 32'd1);
            d = bits[8:1];
            check("sb_nonempty", (sb_q.size() != 0) ? 32'd1 : 32'd0, 32'd1);
            if (sb_q.size() == 0) return;
            e = sb_q.pop_front();
            check("payload", {24'd0, d}, {24'd0, e});
            if (par != 0) begin
                if (f == 0) first_par = bits[9];
                check("parity", {31'd0, bits[9]},
                      {31'd0, (par == 2) ? ^e : ~^e});
            end
        end
    endtask

    task automatic idle_watch(input int ch, input int ncyc, input string tag);
        int lows;
        lows = 0;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            if (txd_w[ch] !== 1'b1) lows++;
        end
        check(tag, lows, 0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int tw;
        resetn = 1'b0;
        en     = '0;
        din    = '0;
        repeat (3) @(negedge clk);
        check("rst_txd", {28'd0, txd_w}, 32'hF);
        check("rst_full", {28'd0, full_w}, 32'h0);
        check("rst_busy", {28'd0, busy_w}, 32'h0);
        check("rst_drop", {28'd0, drop_w}, 32'h0);
        resetn = 1'b1;
        @(negedge clk);

        // single 0x55 frame at default rate
        wr(0, 8'h55, 1);
        tw = cyc;
        check("busy_after_wr", {31'd0, busy_w[0]}, 32'd1);
        rx_frames(0, 1, 1250, 0, 1);
        check("latency_def", first_start - tw, 2);
        check("frame_len_def", cyc - first_start, 12500);
        check("busy_idle_def", {31'd0, busy_w[0]}, 32'd0);

        // four back-to-back frames
        fork
            begin
                wr(1, 8'h01, 1);
                wr(1, 8'h02, 1);
                wr(1, 8'h03, 1);
                wr(1, 8'h04, 1);
                check("no_full4", {31'd0, full_w[1]}, 32'd0);
            end
            rx_frames(1, 4, 16, 0, 1);
        join
        check("sb_empty4", sb_q.size(), 0);

        // six writes, last one dropped
        fork
            begin
                for (int i = 0; i < 5; i++) wr(1, 8'hA0 + 8'(i), 1);
                check("full_after5", {31'd0, full_w[1]}, 32'd1);
                wr(1, 8'hA5, 0);
                check("drop_pulse", {31'd0, drop_w[1]}, 32'd1);
                @(negedge clk);
                check("drop_clear", {31'd0, drop_w[1]}, 32'd0);
            end
            rx_frames(1, 5, 16, 0, 1);
        join
        idle_watch(1, 400, "no_a5_frame");
        check("sb_empty6", sb_q.size(), 0);

        // write while full on the pop cycle
        fork
            begin
                for (int i = 0; i < 5; i++) wr(1, 8'h11 + 8'(i), 1);
                repeat (156) @(negedge clk);
                check("full_prepop", {31'd0, full_w[1]}, 32'd1);
                wr(1, 8'h16, 0);
                check("drop_on_pop", {31'd0, drop_w[1]}, 32'd1);
                check("count_dm1", {31'd0, full_w[1]}, 32'd0);
                @(negedge clk);
                check("drop_on_pop_clr", {31'd0, drop_w[1]}, 32'd0);
            end
            rx_frames(1, 5, 16, 0, 1);
        join
        idle_watch(1, 400, "no_16_frame");
        check("sb_empty_fp", sb_q.size(), 0);

        // parity even, 2 stop bits, back-to-back
        fork
            begin
                wr(2, 8'h07, 1);
                wr(2, 8'h5A, 1);
            end
            rx_frames(2, 2, 16, 2, 2);
        join
        check("even_par_07", {31'd0, first_par}, 32'd1);

        // parity odd
        fork
            wr(3, 8'h07, 1);
            rx_frames(3, 1, 16, 1, 1);
        join
        check("odd_par_07", {31'd0, first_par}, 32'd0);
        check("sb_empty_par", sb_q.size(), 0);

        // reset in the middle of the first of three buffered frames
        wr(1, 8'h31, 0);
        wr(1, 8'h32, 0);
        wr(1, 8'h33, 0);
        repeat (66) @(negedge clk);
        check("pre_rst_txd", {31'd0, txd_w[1]}, 32'd0);
        resetn = 1'b0;
        #1;
        check("mid_rst_txd", {31'd0, txd_w[1]}, 32'd1);
        check("mid_rst_busy", {31'd0, busy_w[1]}, 32'd0);
        check("mid_rst_full", {31'd0, full_w[1]}, 32'd0);
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        idle_watch(1, 600, "rst_no_frames");
        check("rst_busy_after", {31'd0, busy_w[1]}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Buffered UART transmitter: accepts payload words on a single-cycle write strobe into a small FIFO and serialises them onto the transmit pin as start bit, LSB-first payload, optional parity and configurable stop bits. It is the transmit-side counterpart to the UART receiver and sits between user logic (echo path, reporters) and the board's TX pin. Buffering lets a producer issue short bursts without polling busy between bytes.

## Interface
Parameters:
- CLK_HZ, 12000000, clock frequency in Hz
- BIT_RATE, 9600, line rate in bits per second
- PAYLOAD_BITS, 8, data bits per frame (5..9)
- PARITY, 0, 0 = none, 1 = odd, 2 = even
- STOP_BITS, 1, stop bits per frame (1 or 2)
- FIFO_DEPTH, 4, FIFO entries (power of two, >= 2)

Ports (one clock `clk`; reset `resetn` is asynchronous and active-low):
- clk  input  1  system clock
- resetn  input  1  asynchronous active-low reset
- uart_tx_en  input  1  write strobe; one word pushed per high cycle
- uart_tx_data  input  PAYLOAD_BITS  word sampled when uart_tx_en high
- uart_txd  output  1  serial line, idle high
- uart_tx_full  output  1  FIFO holds FIFO_DEPTH words
- uart_tx_busy  output  1  frame in progress or FIFO non-empty
- uart_tx_dropped  output  1  one-cycle pulse: write rejected because FIFO full

## Operation
- CYCLES_PER_BIT = CLK_HZ / BIT_RATE, integer division (1250 at defaults); bit counter width = clog2(CYCLES_PER_BIT).
- FIFO: write pointer, read pointer, count (clog2(FIFO_DEPTH)+1 bits). Push when uart_tx_en && !uart_tx_full. Write while full is discarded (even if a pop occurs the same cycle); uart_tx_dropped pulses next cycle.
- Simultaneous push and pop: both take effect, count unchanged.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: txd = 1. If count != 0 (registered), pop head into shift register, go START.
  - START: txd = 0 for CYCLES_PER_BIT cycles, then DATA.
  - DATA: txd = shift[0]; shift right each bit period; after PAYLOAD_BITS bits go PARITY if PARITY != 0, else STOP.
  - PARITY: txd = XOR of payload (even) or its inverse (odd), one bit period, then STOP.
  - STOP: txd = 1 for STOP_BITS bit periods. At end, if count != 0 pop and go directly to START (no idle gap); else IDLE.
- Parity computed from the popped word, not the shifting register.
- uart_tx_busy = (state != IDLE) || (count != 0).

## Timing
- Reset values: uart_txd = 1, uart_tx_full = 0, uart_tx_busy = 0, uart_tx_dropped = 0, state = IDLE, pointers and count = 0. Reset mid-frame forces txd high immediately (asynchronous) and discards FIFO contents.
- uart_txd is driven from a register; no combinational path from inputs.
- Latency: uart_tx_en high at edge k with FIFO empty and IDLE -> count = 1 after edge k, pop at edge k+1, uart_txd falls after edge k+2.
- Every bit, including start, parity and stop, lasts exactly CYCLES_PER_BIT cycles; frame = (1 + PAYLOAD_BITS + (PARITY!=0) + STOP_BITS) x CYCLES_PER_BIT cycles.
- uart_tx_full and uart_tx_busy reflect registered count/state, valid the cycle after the causing edge.
- Back-to-back frames: last stop bit's final cycle is followed immediately by next start bit.

## Test plan
- Defaults, write 0x55 once -> txd low 1250 cycles, then 1,0,1,0,1,0,1,0 at 1250 cycles each, stop high 1250; busy deasserts the cycle after stop ends; total 12500 cycles.
- Write 0x01,0x02,0x03,0x04 on consecutive cycles -> four frames back-to-back, no idle gap, payloads LSB-first in order, full never asserted.
- Six consecutive writes 0xA0..0xA5 -> 0xA0..0xA4 transmitted, full high after 5th write, dropped pulses once for 0xA5, which never appears.
- PARITY=2, 0x07 -> parity bit 1; PARITY=1, 0x07 -> parity bit 0; STOP_BITS=2 -> stop high 2500 cycles.
- Assert resetn low at mid-DATA of first of three buffered frames -> txd high immediately, busy 0, no further frames after release.
- Write while full at same cycle a pop occurs -> word dropped, count stays FIFO_DEPTH-1, dropped pulses.
